mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle sequencer for the ARM datapath: a Moore FSM steps each instruction through FETCH..WB,
//  driving the mux selects, ALU op and write enables, with condition check and NZCV flag register.
//  Enables a shared instruction/data memory, replacing the single-cycle controller. Counts retired instrs.
// PARAMETERS
//  RETIRE_W  32  width of retired-instruction counter (wraps modulo 2^RETIRE_W)
// PORTS
//  clk         in   1   clock, rising edge
//  reset       in   1   asynchronous, active-high
//  Instr       in   20  IR[31:12]: cond[19:16] op[15:14] funct[13:8] Rd[7:4]
//  ALUFlags    in   4   NZCV from ALU, current cycle
//  MemReady    in   1   memory done (present only with MC_CTRL_STALL_EN)
//  PCWrite     out  1   PC register enable
//  AdrSrc      out  1   memory address: 0=PC, 1=ALUOut
//  MemWrite    out  1   memory write strobe
//  IRWrite     out  1   instruction register enable
//  RegWrite    out  1   register file write enable
//  ResultSrc   out  2   00=ALUOut 01=Data 10=ALUResult
//  ALUSrcA     out  1   0=reg A, 1=PC
//  ALUSrcB     out  2   00=WriteData 01=ExtImm 10=const 4
//  ImmSrc      out  2   = op (combinational)
//  RegSrc      out  2   [0]=1 when op=10; [1]=1 when op=01 & L=0 (STR)
//  ALUControl  out  2   00=ADD 01=SUB 10=AND 11=ORR
//  Retired     out  RETIRE_W  count of executed (non-squashed) instructions
//  State       out  4   current state encoding (debug)
// BEHAVIOUR
//  Reset (async): State=FETCH, Flags=0, CondExReg=0, Retired=0. All outputs are decodes of State/Instr,
//   so during reset outputs equal FETCH decode; MemWrite/RegWrite drop in the cycle reset asserts.
//  Unlisted outputs 0; ALUControl=ADD unless stated.
//  FETCH:    AdrSrc=0 IRWrite=1 ALUSrcA=1 ALUSrcB=10 ResultSrc=10 PCWrite=1 -> DECODE
//  DECODE:   ALUSrcA=1 ALUSrcB=10 ResultSrc=10; CondExReg<=condcheck(cond,Flags).
//            !CondEx -> FETCH (squash, no count); op=01->MEMADR; op=00,I=0->EXECUTER;
//            op=00,I=1->EXECUTEI; op=10->BRANCH; op=11->FETCH (NOP, counted)
//  MEMADR:   ALUSrcA=0 ALUSrcB=01; L=1->MEMREAD, L=0->MEMWRITE
//  MEMREAD:  AdrSrc=1 -> MEMWB
//  MEMWB:    ResultSrc=01 RegWrite=1 -> FETCH
//  MEMWRITE: AdrSrc=1 MemWrite=1 -> FETCH
//  EXECUTER: ALUSrcA=0 ALUSrcB=00; EXECUTEI: ALUSrcA=0 ALUSrcB=01; both -> ALUWB
//            cmd 0100=ADD 0010=SUB 0000=AND 1100=ORR 1010=CMP(SUB); other cmd -> ADD
//            Flags<=ALUFlags at cycle end when S=1 (all 4 bits together); CMP forces update
//  ALUWB:    ResultSrc=00; RegWrite=1 unless CMP; PCWrite=1 if RegWrite and Rd=15 -> FETCH
//  BRANCH:   ALUSrcA=0 ALUSrcB=01 ResultSrc=10 PCWrite=1 -> FETCH
//  Retired+1 on every transition into FETCH except DECODE squash; wraps to 0.
//  Cond codes EQ..LE per ARM; 1110 AL and 1111 both always execute. Condition uses Flags
//   as of DECODE; S-instruction flags visible to the following instruction.
//  Latency (no stalls): data-proc 4, LDR 5, STR 4, B 3, squashed 2 cycles.
// CONFIGURATION
//  MC_CTRL_STALL_EN defined: MemReady port exists; FETCH, MEMREAD, MEMWRITE hold while MemReady=0;
//   PCWrite/IRWrite asserted only in the FETCH cycle with MemReady=1; MemWrite held until MemReady=1.
//  Undefined: no MemReady port; behaves as MemReady=1 constantly.
// STRUCTURE
//  Package mc_ctrl_pkg: state_t enum, ALUControl/ResultSrc/ALUSrcB encodings, cond-code constants.
//  Sub-module cond_check: combinational (cond, NZCV) -> CondEx.
// TESTING
//  1 Reset asserted in MEMWRITE -> MemWrite=0 same cycle, State=FETCH, Retired=0, Flags=0
//  2 ADD imm (cond=1110 op=00 funct=101000) -> FETCH,DECODE,EXECUTEI,ALUWB; RegWrite only in ALUWB; Retired=1
//  3 SUBS with ALUFlags=0100 then BEQ (cond=0000 op=10) -> BRANCH, PCWrite=1; with Z=0 -> DECODE->FETCH, Retired unchanged
//  4 LDR (op=01 L=1) -> 5 states, ImmSrc=01, ResultSrc=01 in MEMWB; STR -> MemWrite only in MEMWRITE, RegSrc=10
//  5 CMP (funct=110101) -> ALUControl=01, Flags<=ALUFlags, RegWrite=0 in ALUWB; RETIRE_W=4, 16 instrs -> Retired=0
//  6 MC_CTRL_STALL_EN, MemReady=0 3 cycles in FETCH -> State=FETCH, PCWrite=0, IRWrite=0 until MemReady=1

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath mux selects,
// ALU operations, instruction field codes and condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unrecognised data-processing commands fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD: alu_decode = ALU_ADD;
            CMD_SUB: alu_decode = ALU_SUB;
            CMD_CMP: alu_decode = ALU_SUB;
            CMD_AND: alu_decode = ALU_AND;
            CMD_ORR: alu_decode = ALU_ORR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against the stored NZCV flags.
module cond_check
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);

    logic w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = i_flags;

    // Both 1110 (AL) and the 1111 encoding execute unconditionally.
    always_comb begin
        o_condex = 1'b1;
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = (w_n == w_v);
            COND_LT: o_condex = (w_n != w_v);
            COND_GT: o_condex = ~w_z & (w_n == w_v);
            COND_LE: o_condex = w_z | (w_n != w_v);
            default: o_condex = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle Moore sequencer for the ARM datapath with NZCV flag register and retire counter.
// Define MC_CTRL_STALL_EN to add the MemReady handshake that holds FETCH/MEMREAD/MEMWRITE.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [19:0]         Instr,
    input  logic [3:0]          ALUFlags,
`ifdef MC_CTRL_STALL_EN
    input  logic                MemReady,
`endif
    output logic                PCWrite,
    output logic                AdrSrc,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmSrc,
    output logic [1:0]          RegSrc,
    output logic [1:0]          ALUControl,
    output logic [RETIRE_W-1:0] Retired,
    output logic [3:0]          State
);

    state_t              r_state;
    logic [3:0]          r_flags;
    logic                r_condex;
    logic [RETIRE_W-1:0] r_retired;

    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic       w_imm;
    logic [3:0] w_cmd;
    logic       w_sbit;
    logic [3:0] w_rd;
    logic       w_is_cmp;
    logic       w_ready;
    logic       w_condex;
    logic       w_unused_instr;

    assign w_cond         = Instr[19:16];
    assign w_op           = Instr[15:14];
    assign w_imm          = Instr[13];
    assign w_cmd          = Instr[12:9];
    assign w_sbit         = Instr[8];
    assign w_rd           = Instr[7:4];
    assign w_is_cmp       = (w_cmd == CMD_CMP);
    assign w_unused_instr = ^Instr[3:0];

`ifdef MC_CTRL_STALL_EN
    assign w_ready = MemReady;
`else
    assign w_ready = 1'b1;
`endif

    cond_check u_cond_check (
        .i_cond   (w_cond),
        .i_flags  (r_flags),
        .o_condex (w_condex)
    );

    // Every return to FETCH retires an instruction except a DECODE condition squash.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_condex  <= 1'b0;
            r_retired <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_condex <= w_condex;
                    if (!w_condex) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (w_op)
                            OP_MEM:  r_state <= S_MEMADR;
                            OP_DP:   r_state <= w_imm ? S_EXECUTEI : S_EXECUTER;
                            OP_BR:   r_state <= S_BRANCH;
                            default: begin
                                r_state   <= S_FETCH;
                                r_retired <= r_retired + 1'b1;
                            end
                        endcase
                    end
                end
                S_MEMADR: r_state <= w_sbit ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (w_ready) r_state <= S_MEMWB;
                end
                S_MEMWRITE: begin
                    if (w_ready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + 1'b1;
                    end
                end
                S_EXECUTER, S_EXECUTEI: begin
                    if (w_sbit || w_is_cmp) r_flags <= ALUFlags;
                    r_state <= S_ALUWB;
                end
                S_MEMWB, S_ALUWB, S_BRANCH: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + 1'b1;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WDATA;
        ALUControl = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                PCWrite   = w_ready;
                IRWrite   = w_ready;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = r_condex;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = r_condex;
            end
            S_EXECUTER: ALUControl = alu_decode(w_cmd);
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_decode(w_cmd);
            end
            S_ALUWB: begin
                RegWrite = r_condex & ~w_is_cmp;
                PCWrite  = r_condex & ~w_is_cmp & (w_rd == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = r_condex;
            end
            default: ;
        endcase
    end

    assign ImmSrc  = w_op;
    assign RegSrc  = {(w_op == OP_MEM) & ~w_sbit, (w_op == OP_BR)};
    assign Retired = r_retired;
    assign State   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: table of instructions with per-cycle expected state and control
// outputs fed through a scoreboard queue, plus reset, retire-wrap and stall sequences.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [19:0]   Instr;
    logic [3:0]    ALUFlags;
`ifdef MC_CTRL_STALL_EN
    logic          MemReady;
`endif
    logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]    ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [RW-1:0] Retired;
    logic [3:0]    State;

    mc_controller #(.RETIRE_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
`ifdef MC_CTRL_STALL_EN
        .MemReady   (MemReady),
`endif
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .Retired    (Retired),
        .State      (State)
    );

    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl}
    logic [11:0] w_ctl;
    assign w_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl};

    typedef struct {
        string           name;
        logic [19:0]     instr;
        logic [3:0]      alufl;
        int              ncyc;
        logic [4:0][3:0] seq;
        logic [1:0]      aluc;
        logic            rw;
        logic            pcw;
        logic [1:0]      imm;
        logic [1:0]      rsrc;
        int              dret;
    } vec_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [11:0] ctl;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    logic [RW-1:0] exp_ret = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic logic [4:0][3:0] mkseq(input state_t a, input state_t b, input state_t c,
                                              input state_t d, input state_t e);
        mkseq[0] = a; mkseq[1] = b; mkseq[2] = c; mkseq[3] = d; mkseq[4] = e;
    endfunction

    function automatic vec_t mkv(input string nm, input logic [19:0] ins, input logic [3:0] fl,
                                 input int n, input logic [4:0][3:0] sq, input logic [1:0] ac,
                                 input logic rw, input logic pcw, input logic [1:0] imm,
                                 input logic [1:0] rs, input int dr);
        vec_t v;
        v.name = nm; v.instr = ins; v.alufl = fl; v.ncyc = n; v.seq = sq; v.aluc = ac;
        v.rw = rw; v.pcw = pcw; v.imm = imm; v.rsrc = rs; v.dret = dr;
        return v;
    endfunction

    // Control outputs expected in each state, straight from the state table.
    function automatic logic [11:0] exp_ctl(input logic [3:0] st, input logic [1:0] ac,
                                            input logic rw, input logic pcw);
        case (st)
            S_FETCH:    exp_ctl = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
            S_DECODE:   exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00};
            S_MEMADR:   exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00};
            S_MEMREAD:  exp_ctl = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
            S_MEMWB:    exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00};
            S_MEMWRITE: exp_ctl = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00};
            S_EXECUTER: exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, ac};
            S_EXECUTEI: exp_ctl = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, ac};
            S_ALUWB:    exp_ctl = {pcw,  1'b0, 1'b0, 1'b0, rw,   2'b00, 1'b0, 2'b00, 2'b00};
            S_BRANCH:   exp_ctl = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00};
            default:    exp_ctl = 12'hFFF;
        endcase
    endfunction

    // Entered just after a falling edge with the DUT in FETCH; returns the same way.
    task automatic run_vec(input vec_t v);
        exp_t e;
        Instr    = v.instr;
        ALUFlags = v.alufl;
        for (int c = 0; c < v.ncyc; c++) begin
            e.st  = v.seq[c];
            e.ctl = exp_ctl(v.seq[c], v.aluc, v.rw, v.pcw);
            sbq.push_back(e);
        end
        for (int c = 0; c < v.ncyc; c++) begin
            #1;
            e = sbq.pop_front();
            chk({v.name, "_state"}, 32'(State), 32'(e.st));
            chk({v.name, "_ctl"}, 32'(w_ctl), 32'(e.ctl));
            if (c == 0) begin
                chk({v.name, "_immsrc"}, 32'(ImmSrc), 32'(v.imm));
                chk({v.name, "_regsrc"}, 32'(RegSrc), 32'(v.rsrc));
            end
            @(negedge clk);
        end
        exp_ret = exp_ret + RW'(v.dret);
        #1;
        chk({v.name, "_retired"}, 32'(Retired), 32'(exp_ret));
    endtask

    localparam logic [19:0] I_NOP = {4'hE, 2'b11, 6'h00, 8'h00};
    localparam logic [19:0] I_BEQ = {4'h0, 2'b10, 6'h00, 8'h00};

    initial begin
        vec_t nopv, beqv, subsv;
        reset    = 1'b1;
        Instr    = I_NOP;
        ALUFlags = 4'h0;
`ifdef MC_CTRL_STALL_EN
        MemReady = 1'b1;
`endif
        nopv  = mkv("nop", I_NOP, 4'h0, 2, mkseq(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH),
                    ALU_ADD, 1'b0, 1'b0, 2'b11, 2'b00, 1);
        beqv  = mkv("beq_squash", I_BEQ, 4'h0, 2, mkseq(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH),
                    ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 0);
        subsv = mkv("subs_reg", {4'hE, 2'b00, 6'b000101, 4'h2, 4'h0}, 4'b0100, 4,
                    mkseq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), ALU_SUB, 1'b1, 1'b0, 2'b00, 2'b00, 1);

        vecs.push_back(beqv);
        vecs.push_back(mkv("add_imm", {4'hE, 2'b00, 6'b101000, 4'h1, 4'h0}, 4'h0, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), ALU_ADD, 1'b1, 1'b0, 2'b00, 2'b00, 1));
        vecs.push_back(subsv);
        vecs.push_back(mkv("beq_taken", I_BEQ, 4'h0, 3,
            mkseq(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 1));
        vecs.push_back(mkv("ldr", {4'hE, 2'b01, 6'b011001, 4'h3, 4'h0}, 4'h0, 5,
            mkseq(S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB), ALU_ADD, 1'b0, 1'b0, 2'b01, 2'b00, 1));
        vecs.push_back(mkv("str", {4'hE, 2'b01, 6'b011000, 4'h3, 4'h0}, 4'h0, 4,
            mkseq(S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b01, 2'b10, 1));
        vecs.push_back(mkv("cmp", {4'hE, 2'b00, 6'b110101, 4'h0, 4'h0}, 4'b1000, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTEI, S_ALUWB, S_FETCH), ALU_SUB, 1'b0, 1'b0, 2'b00, 2'b00, 1));
        vecs.push_back(mkv("bmi_taken", {4'h4, 2'b10, 6'h00, 8'h00}, 4'h0, 3,
            mkseq(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 1));
        vecs.push_back(mkv("bne_taken", {4'h1, 2'b10, 6'h00, 8'h00}, 4'h0, 3,
            mkseq(S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 1));
        vecs.push_back(mkv("bpl_squash", {4'h5, 2'b10, 6'h00, 8'h00}, 4'h0, 2,
            mkseq(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 0));
        vecs.push_back(mkv("orr_pc", {4'hE, 2'b00, 6'b011000, 4'hF, 4'h0}, 4'h0, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), ALU_ORR, 1'b1, 1'b1, 2'b00, 2'b00, 1));
        vecs.push_back(mkv("and_nos", {4'hE, 2'b00, 6'b000000, 4'h5, 4'h0}, 4'hF, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), ALU_AND, 1'b1, 1'b0, 2'b00, 2'b00, 1));
        vecs.push_back(mkv("bvs_squash", {4'h6, 2'b10, 6'h00, 8'h00}, 4'h0, 2,
            mkseq(S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH), ALU_ADD, 1'b0, 1'b0, 2'b10, 2'b01, 0));
        vecs.push_back(nopv);
        vecs.push_back(mkv("cmd_other", {4'hE, 2'b00, 6'b001100, 4'h6, 4'h0}, 4'h0, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), ALU_ADD, 1'b1, 1'b0, 2'b00, 2'b00, 1));
        vecs.push_back(mkv("cond_1111", {4'hF, 2'b00, 6'b001000, 4'h4, 4'h0}, 4'h0, 4,
            mkseq(S_FETCH, S_DECODE, S_EXECUTER, S_ALUWB, S_FETCH), ALU_ADD, 1'b1, 1'b0, 2'b00, 2'b00, 1));

        // Outputs during reset decode as FETCH.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(State), 32'(S_FETCH));
        chk("reset_ctl", 32'(w_ctl), 32'(exp_ctl(S_FETCH, ALU_ADD, 1'b0, 1'b0)));
        chk("reset_retired", 32'(Retired), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset asserted mid-MEMWRITE after an S instruction left Z=1.
        run_vec(subsv);
        Instr = {4'hE, 2'b01, 6'b011000, 4'h3, 4'h0};
        repeat (3) @(negedge clk);
        #1;
        chk("rstmw_pre_state", 32'(State), 32'(S_MEMWRITE));
        chk("rstmw_pre_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rstmw_memwrite", 32'(MemWrite), 32'd0);
        chk("rstmw_state", 32'(State), 32'(S_FETCH));
        chk("rstmw_retired", 32'(Retired), 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = '0;
        run_vec(beqv);

        // Retire counter wraps modulo 2^RW.
        for (int n = 0; n < 16; n++) run_vec(nopv);
        chk("retire_wrap", 32'(Retired), 32'd0);

`ifdef MC_CTRL_STALL_EN
        Instr    = {4'hE, 2'b00, 6'b101000, 4'h1, 4'h0};
        MemReady = 1'b0;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk("stall_state", 32'(State), 32'(S_FETCH));
            chk("stall_pcwrite", 32'(PCWrite), 32'd0);
            chk("stall_irwrite", 32'(IRWrite), 32'd0);
            @(negedge clk);
        end
        MemReady = 1'b1;
        #1;
        chk("stall_rel_pcwrite", 32'(PCWrite), 32'd1);
        chk("stall_rel_irwrite", 32'(IRWrite), 32'd1);
        @(negedge clk);
        #1;
        chk("stall_rel_state", 32'(State), 32'(S_DECODE));
        repeat (3) @(negedge clk);
        #1;
        chk("stall_done_state", 32'(State), 32'(S_FETCH));
        chk("stall_done_retired", 32'(Retired), 32'(exp_ret + 1'b1));
`endif

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
